tv_capture_recorder: RTL and testbench

//  Writer-side counterpart of our test-vector flow: samples {inputs,expected-output} words from a
//  DUT harness, stores them in an internal register file, appends a terminator word, then streams
//  the buffer out over a valid/ready port. The drained image is in test-vector file format:

---
 rtl/tv_recorder_pkg.sv | 23 ++
 rtl/tv_regfile.sv | 39 +++
 rtl/tv_capture_recorder.sv | 191 +++++++++++++++++++
 tb/tb_tv_capture_recorder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/tv_recorder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tv_recorder_pkg
// Purpose  : Shared types and defaults for the test-vector capture recorder.
//            Holds the recorder FSM state encoding and the default
//            terminator word that closes every drained vector image.
// Revision : 1.0 - initial release
// ============================================================================
package tv_recorder_pkg;

  // Recorder FSM states, explicitly 2 bits wide.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CAPTURE   = 2'd1,
    TERMINATE = 2'd2,
    DRAIN     = 2'd3
  } state_t;

  // Terminator value appended after the last captured sample.
  localparam int TERM_WORD_DEFAULT = 8;

endpackage
`default_nettype wire

// File: rtl/tv_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tv_regfile
// Purpose  : DEPTH x WIDTH register file. One synchronous write port and
//            one asynchronous (combinational) read port. Contents are not
//            reset.
// Ports    : clk      - clock, write happens on rising edge
//            wr_en    - write enable
//            wr_addr  - write address
//            wr_data  - write data
//            rd_addr  - read address
//            rd_data  - read data, combinational from rd_addr
// Revision : 1.0 - initial release
// ============================================================================
module tv_regfile #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/tv_capture_recorder.sv
`default_nettype none
// ============================================================================
// Module   : tv_capture_recorder
// Purpose  : Captures {inputs,expected-output} words from a DUT harness into
//            a register file, appends a terminator word, then streams the
//            buffer out oldest-first over a valid/ready port. The drained
//            image is a test-vector file: data words then the terminator.
// Ports    : clk          - clock, rising edge
//            reset        - synchronous, active-low
//            start        - begin a capture (IDLE only)
//            stop         - end the capture (CAPTURE only)
//            sample_valid - sample_in is captured this cycle (CAPTURE only)
//            sample_in    - word to capture
//            busy         - high while not IDLE
//            count        - samples stored, terminator excluded
//            overflow     - sticky, a sample was offered with no free slot
//            rd_valid     - rd_data holds a buffered word (DRAIN)
//            rd_ready     - consumer accepts rd_data
//            rd_data      - current drained word
//            rd_last      - rd_data is the terminator
//            done         - one-cycle pulse after the terminator transfers
// Revision : 1.0 - initial release
// ============================================================================
module tv_capture_recorder
  import tv_recorder_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter int               DEPTH     = 16,
  parameter logic [WIDTH-1:0] TERM_WORD = WIDTH'(TERM_WORD_DEFAULT)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       sample_valid,
  input  logic [WIDTH-1:0]           sample_in,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_last,
  output logic                       done
);

  localparam int c_addr_w = $clog2(DEPTH);
  localparam int c_cnt_w  = $clog2(DEPTH+1);
  // Count value whose increment fills the last data slot; the final entry
  // is reserved for the terminator.
  localparam logic [c_cnt_w-1:0] c_last_fill = c_cnt_w'(DEPTH-2);

  state_t r_state;
  state_t w_state_next;

  logic [c_addr_w-1:0] r_wr_ptr;
  logic [c_addr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0]  r_count;
  logic                r_overflow;
  logic                r_done;
  logic                r_busy;

  logic                w_clear;
  logic                w_sample_we;
  logic                w_term_we;
  logic                w_drop;
  logic                w_xfer;
  logic                w_drain;
  logic                w_last;
  logic                w_we;
  logic [WIDTH-1:0]    w_wdata;
  logic [WIDTH-1:0]    w_rd_data;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  assign w_last = (r_rd_ptr == r_wr_ptr);

  // --------------------------------------------------------------------------
  // FSM next-state and control decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_sample_we  = 1'b0;
    w_term_we    = 1'b0;
    w_drop       = 1'b0;
    w_xfer       = 1'b0;
    w_drain      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_clear      = 1'b1;
          w_state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        w_sample_we = sample_valid;
        // A sample coinciding with stop is stored before terminating.
        if (stop || (sample_valid && (r_count == c_last_fill))) begin
          w_state_next = TERMINATE;
        end
      end
      TERMINATE: begin
        w_term_we    = 1'b1;
        w_drop       = sample_valid;
        w_state_next = DRAIN;
      end
      DRAIN: begin
        w_drain = 1'b1;
        w_xfer  = rd_ready;
        if (rd_ready && w_last) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Pointers, count, status flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_done <= w_xfer && w_last;
      r_busy <= (w_state_next != IDLE);
      if (w_clear) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end
      if (w_sample_we) begin
        r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
        r_count  <= r_count + c_cnt_w'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_xfer) begin
        r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Register file: samples in CAPTURE, terminator in TERMINATE
  // --------------------------------------------------------------------------
  assign w_we    = w_sample_we | w_term_we;
  assign w_wdata = w_term_we ? TERM_WORD : sample_in;

  tv_regfile #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (c_addr_w)
  ) u_regfile (
    .clk     (clk),
    .wr_en   (w_we),
    .wr_addr (r_wr_ptr),
    .wr_data (w_wdata),
    .rd_addr (r_rd_ptr),
    .rd_data (w_rd_data)
  );

  assign busy     = r_busy;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign done     = r_done;
  assign rd_valid = w_drain;
  assign rd_data  = w_rd_data;
  assign rd_last  = w_drain && w_last;

endmodule
`default_nettype wire

// File: tb/tb_tv_capture_recorder.sv
`default_nettype none
// ============================================================================
// Module   : tb_tv_capture_recorder
// Purpose  : Directed self-checking bench for tv_capture_recorder
//            (WIDTH=4, DEPTH=16, TERM_WORD=4'b1000).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tv_capture_recorder;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic       sample_valid;
  logic [3:0] sample_in;
  logic       busy;
  logic [4:0] count;
  logic       overflow;
  logic       rd_valid;
  logic       rd_ready;
  logic [3:0] rd_data;
  logic       rd_last;
  logic       done;

  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0] exp_q[$];

  tv_capture_recorder #(
    .WIDTH     (4),
    .DEPTH     (16),
    .TERM_WORD (4'b1000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .busy         (busy),
    .count        (count),
    .overflow     (overflow),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .rd_last      (rd_last),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Drains exp_q.size() words. When toggle is set, rd_ready follows the
  // repeating pattern 1,0,0,1; rd_data/rd_last are checked every cycle,
  // so stalled cycles must present the same word.
  task automatic drain(input string tag, input bit toggle);
    int idx = 0;
    int cyc = 0;
    int n   = exp_q.size();
    logic [3:0] pat = 4'b1001;
    while (idx < n && cyc < 200) begin
      rd_ready = toggle ? pat[cyc % 4] : 1'b1;
      check({tag, "_valid"}, rd_valid, 1'b1);
      check({tag, "_data"},  rd_data,  exp_q[idx]);
      check({tag, "_last"},  rd_last,  (idx == n - 1));
      if (rd_ready) idx++;
      tick();
      cyc++;
    end
    rd_ready = 1'b0;
    check({tag, "_words"}, idx, n);
    check({tag, "_done"},  done, 1'b1);
    check({tag, "_idle"},  busy, 1'b0);
    check({tag, "_rdv0"},  rd_valid, 1'b0);
    tick();
    check({tag, "_done_once"}, done, 1'b0);
  endtask

  initial begin
    reset        = 1'b0;
    start        = 1'b0;
    stop         = 1'b0;
    sample_valid = 1'b0;
    sample_in    = 4'h0;
    rd_ready     = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    check("rst_busy",     busy,     1'b0);
    check("rst_count",    count,    5'd0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_done",     done,     1'b0);

    // 1: three samples, stop, drain with terminator
    start = 1'b1; tick(); start = 1'b0;
    check("t1_busy", busy, 1'b1);
    sample_valid = 1'b1;
    sample_in = 4'b0011; tick();
    sample_in = 4'b0101; tick();
    sample_in = 4'b1110; tick();
    sample_valid = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    check("t1_count", count, 5'd3);
    check("t1_term_rdv", rd_valid, 1'b0);
    tick();
    exp_q = '{4'b0011, 4'b0101, 4'b1110, 4'b1000};
    drain("t1", 1'b0);
    check("t1_count_idle", count, 5'd3);

    // 2: hold sample_valid 20 cycles -> fills at 15, overflow in TERMINATE
    start = 1'b1; tick(); start = 1'b0;
    sample_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sample_in = 4'(i);
      tick();
    end
    sample_valid = 1'b0;
    check("t2_count",    count,    5'd15);
    check("t2_overflow", overflow, 1'b1);
    check("t2_busy",     busy,     1'b1);
    exp_q.delete();
    for (int i = 0; i < 15; i++) exp_q.push_back(4'(i));
    exp_q.push_back(4'b1000);
    drain("t2", 1'b0);
    check("t2_ovf_hold",   overflow, 1'b1);
    check("t2_count_hold", count,    5'd15);

    // 3: stalled drain
    start = 1'b1; tick(); start = 1'b0;
    check("t3_ovf_clr",   overflow, 1'b0);
    check("t3_count_clr", count,    5'd0);
    sample_valid = 1'b1;
    sample_in = 4'h9; tick();
    sample_in = 4'hA; tick();
    sample_in = 4'h6; tick();
    sample_valid = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    tick();
    exp_q = '{4'h9, 4'hA, 4'h6, 4'b1000};
    drain("t3", 1'b1);

    // 4: zero-sample capture
    start = 1'b1; tick(); start = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    check("t4_count", count, 5'd0);
    tick();
    exp_q = '{4'b1000};
    drain("t4", 1'b0);

    // 5: sample with stop; start during DRAIN ignored
    start = 1'b1; tick(); start = 1'b0;
    sample_valid = 1'b1; sample_in = 4'b0111; stop = 1'b1;
    tick();
    sample_valid = 1'b0; stop = 1'b0;
    check("t5_count", count, 5'd1);
    tick();
    start = 1'b1; tick(); start = 1'b0;
    check("t5_busy_drain", busy, 1'b1);
    check("t5_held_data",  rd_data, 4'b0111);
    exp_q = '{4'b0111, 4'b1000};
    drain("t5", 1'b0);
    check("t5_count_idle", count, 5'd1);

    // 6: reset mid-capture and mid-drain
    start = 1'b1; tick(); start = 1'b0;
    sample_valid = 1'b1;
    sample_in = 4'h2; tick();
    sample_in = 4'h3; tick();
    sample_valid = 1'b0;
    reset = 1'b0; tick(); reset = 1'b1;
    check("t6a_busy",  busy,     1'b0);
    check("t6a_rdv",   rd_valid, 1'b0);
    check("t6a_count", count,    5'd0);
    start = 1'b1; tick(); start = 1'b0;
    sample_valid = 1'b1; sample_in = 4'hC; tick();
    sample_valid = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    tick();
    check("t6b_rdv", rd_valid, 1'b1);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    check("t6b_mid", rd_data, 4'b1000);
    reset = 1'b0; tick(); reset = 1'b1;
    check("t6b_busy",  busy,     1'b0);
    check("t6b_rdv0",  rd_valid, 1'b0);
    check("t6b_count", count,    5'd0);
    check("t6b_done",  done,     1'b0);
    start = 1'b1; tick(); start = 1'b0;
    sample_valid = 1'b1;
    sample_in = 4'hD; tick();
    sample_in = 4'hE; tick();
    sample_valid = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    check("t6c_count", count, 5'd2);
    tick();
    exp_q = '{4'hD, 4'hE, 4'b1000};
    drain("t6c", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
